// File: rtl/steer_en_ctrl.sv
// Rider-detect and steer-enable controller: captures load cells, checks
// weight/imbalance thresholds and times a balanced stance before steering.
module steer_en_ctrl #(
  parameter int LD_W        = 12,
  parameter int MIN_WT      = 512,
  parameter int WT_HYST     = 64,
  parameter int TMR_CYCLES  = 67000000,
  parameter int FAST_SIM    = 1,
  parameter int FAST_CYCLES = 32768,
  parameter int LO_SHIFT    = 2,
  parameter int HI_SHIFT    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwr_en,
  input  logic            ld_vld,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      state,
  output logic [LD_W:0]   rider_wt
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } st_e;

  localparam int T  = (FAST_SIM != 0) ? FAST_CYCLES : TMR_CYCLES;
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam logic [TW-1:0] TMAX = TW'(T - 1);
  localparam logic [LD_W:0] WT_HI = (LD_W+1)'(MIN_WT + WT_HYST);
  localparam logic [LD_W:0] WT_LO = (LD_W+1)'(MIN_WT - WT_HYST);

  logic [LD_W-1:0] r_lft;
  logic [LD_W-1:0] r_rght;
  logic [LD_W:0]   r_wt;
  logic [TW-1:0]   r_tmr;
  st_e             r_state;

  st_e                 w_nxt;
  logic                w_clr;
  logic                w_inc;
  logic signed [LD_W:0] w_diff;
  logic [LD_W:0]       w_mag;
  logic                w_gt_min;
  logic                w_lt_min;
  logic                w_unbal_lo;
  logic                w_unbal_hi;
  logic                w_tmr_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft  <= '0;
      r_rght <= '0;
      r_wt   <= '0;
    end else if (ld_vld) begin
      r_lft  <= lft_ld;
      r_rght <= rght_ld;
      r_wt   <= {1'b0, lft_ld} + {1'b0, rght_ld};
    end
  end

  // Sign-extended subtract so |diff| of a full-scale split cannot wrap
  assign w_diff = $signed({1'b0, r_rght}) - $signed({1'b0, r_lft});
  assign w_mag  = w_diff[LD_W] ? $unsigned(-w_diff)
                               : $unsigned(w_diff);

  assign w_gt_min   = r_wt > WT_HI;
  assign w_lt_min   = r_wt < WT_LO;
  assign w_unbal_lo = w_mag > (r_wt >> LO_SHIFT);
  assign w_unbal_hi = w_mag > (r_wt - (r_wt >> HI_SHIFT));
  assign w_tmr_full = r_tmr == TMAX;

  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    w_inc = 1'b0;
    if (!pwr_en) begin
      w_nxt = OFF;
      w_clr = 1'b1;
    end else begin
      unique case (r_state)
        OFF: begin
          if (w_gt_min) begin
            w_nxt = WAIT;
            w_clr = 1'b1;
          end
        end
        WAIT: begin
          if (w_lt_min) begin
            w_nxt = OFF;
          end else if (w_unbal_lo) begin
            w_clr = 1'b1;
          end else if (w_tmr_full) begin
            w_nxt = STEER;
          end else begin
            w_inc = 1'b1;
          end
        end
        STEER: begin
          if (w_lt_min) begin
            w_nxt = OFF;
          end else if (w_unbal_hi) begin
            w_nxt = WAIT;
            w_clr = 1'b1;
          end
        end
        default: w_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_tmr   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_clr)
        r_tmr <= '0;
      else if (w_inc && !w_tmr_full)
        r_tmr <= r_tmr + 1'b1;
    end
  end

  assign state     = r_state;
  assign rider_wt  = r_wt;
  assign en_steer  = r_state == STEER;
  assign rider_off = !(r_state == WAIT || r_state == STEER);

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl: threshold vector table plus
// multi-cycle timer, dropout, override and reset sequences.
module tb_steer_en_ctrl;

  localparam int T = 4096;

  logic        clk;
  logic        rst_n;
  logic        pwr_en;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;
  logic [1:0]  state;
  logic [12:0] rider_wt;

  int n_chk;
  int n_fail;

  steer_en_ctrl #(
    .FAST_SIM    (1),
    .FAST_CYCLES (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_en    (pwr_en),
    .ld_vld    (ld_vld),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .en_steer  (en_steer),
    .rider_off (rider_off),
    .state     (state),
    .rider_wt  (rider_wt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pwr;
    logic        vld;
    logic [11:0] l;
    logic [11:0] r;
    logic [1:0]  st;
    logic [12:0] wt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
    ld_vld  = 1'b1;
    step();
    ld_vld  = 1'b0;
  endtask

  // Call right after the edge that cleared the timer with a balanced
  // sample captured; steering must come exactly T edges later.
  task automatic count_steer(input string nm);
    int cnt;
    cnt = 0;
    while (!en_steer && cnt < T + 16) begin
      step();
      cnt++;
    end
    chk(nm, cnt, T);
  endtask

  task automatic chk_out(input string nm, input int st, input int wt);
    chk({nm, "_state"}, state, st);
    chk({nm, "_en"}, en_steer, (st == 2) ? 1 : 0);
    chk({nm, "_off"}, rider_off, (st == 0) ? 1 : 0);
    if (wt >= 0)
      chk({nm, "_wt"}, rider_wt, wt);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tbl[0]  = '{1'b1, 1'b1, 12'h120, 12'h120, 2'd0, 13'd576};
    tbl[1]  = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd0, 13'd576};
    tbl[2]  = '{1'b1, 1'b1, 12'h120, 12'h121, 2'd0, 13'd577};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd1, 13'd577};
    tbl[4]  = '{1'b1, 1'b1, 12'h200, 12'h080, 2'd1, 13'd640};
    tbl[5]  = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd1, 13'd640};
    tbl[6]  = '{1'b1, 1'b1, 12'h0C0, 12'h0C0, 2'd1, 13'd384};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd0, 13'd384};
    tbl[8]  = '{1'b1, 1'b1, 12'hFFF, 12'h000, 2'd0, 13'd4095};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd1, 13'd4095};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd1, 13'd4095};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 12'h000, 2'd0, 13'd4095};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd1, 13'd4095};
    tbl[13] = '{1'b1, 1'b1, 12'h000, 12'h100, 2'd1, 13'd256};
    tbl[14] = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd0, 13'd256};
    tbl[15] = '{1'b1, 1'b1, 12'h100, 12'h100, 2'd0, 13'd512};
    tbl[16] = '{1'b1, 1'b0, 12'h000, 12'h000, 2'd0, 13'd512};

    rst_n   = 1'b0;
    pwr_en  = 1'b1;
    ld_vld  = 1'b0;
    lft_ld  = 12'h150;
    rght_ld = 12'h150;
    step();
    step();
    chk_out("reset", 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("post_rst", 0, 0);

    for (int i = 0; i < 17; i++) begin
      pwr_en  = tbl[i].pwr;
      ld_vld  = tbl[i].vld;
      lft_ld  = tbl[i].l;
      rght_ld = tbl[i].r;
      step();
      chk_out($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].wt));
    end
    ld_vld = 1'b0;
    pwr_en = 1'b1;

    // Mount and time
    strobe(12'h150, 12'h150);
    chk_out("mnt_cap", 0, 672);
    step();
    chk_out("mnt_wait", 1, 672);
    count_steer("mnt_time");
    chk_out("mnt_steer", 2, 672);

    // Full-scale split: no wrap, unbal_hi drops to WAIT
    strobe(12'hFFF, 12'h000);
    chk_out("fs_cap", 2, 4095);
    step();
    chk_out("fs_drop", 1, 4095);
    strobe(12'h150, 12'h150);
    count_steer("fs_time");

    // Steer dropout and rebalance
    strobe(12'h260, 12'h000);
    step();
    chk_out("drop", 1, 608);
    strobe(12'h130, 12'h130);
    count_steer("rebal_time");
    chk_out("rebal_steer", 2, 608);

    // Low threshold while steering
    strobe(12'h0E0, 12'h0E0);
    step();
    step();
    chk_out("thr448", 2, 448);
    strobe(12'h0DF, 12'h0E0);
    step();
    chk_out("thr447", 0, 447);

    strobe(12'h150, 12'h150);
    step();
    count_steer("remount_time");

    // Power-enable override
    pwr_en = 1'b0;
    step();
    chk_out("pwr_off", 0, 672);
    pwr_en = 1'b1;
    step();
    chk_out("pwr_on", 1, 672);
    count_steer("pwr_time");

    // Unbalanced wait never times out
    strobe(12'h260, 12'h000);
    step();
    chk_out("ub_enter", 1, 608);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < T + 2000; i++) begin
        if (i % 1000 == 0) begin
          lft_ld  = 12'h200;
          rght_ld = 12'h080;
          ld_vld  = 1'b1;
        end
        step();
        ld_vld = 1'b0;
        if (state != 2'd1 || en_steer)
          bad++;
      end
      chk("ub_hold", bad, 0);
    end
    strobe(12'h150, 12'h150);
    count_steer("ub_rebal_time");

    // Timer full and unbalance on the same edge: unbalance wins
    strobe(12'h260, 12'h000);
    step();
    strobe(12'h150, 12'h150);
    for (int i = 0; i < T - 2; i++)
      step();
    chk_out("race_pre", 1, 672);
    strobe(12'h200, 12'h080);
    step();
    chk_out("race_edge", 1, 640);
    step();
    step();
    chk_out("race_hold", 1, 640);
    strobe(12'h150, 12'h150);
    count_steer("race_time");

    // Asynchronous reset mid-steer
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_out("rst_hold", 0, 0);
    strobe(12'h150, 12'h150);
    chk_out("rst_cap", 0, 672);
    step();
    chk_out("rst_wait", 1, 672);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
- Parametrised rider-detect and steer-enable controller for the segway.
- Captures the left and right load-cell samples on an A2D valid strobe, then computes total weight and left/right imbalance against parametrised thresholds.
- Contains its own timer and a three-state FSM, plus a power-enable override.
- Drives en_steer to the steering/balance path, and rider_off and a state code to the auth and power logic.

Parameters:
- LD_W, 12: load-cell sample width in bits.
- MIN_WT, 512: nominal minimum rider weight in load-cell counts.
- WT_HYST, 64: hysteresis band around MIN_WT.
- TMR_CYCLES, 67000000: clk cycles of balanced stance required before steering is enabled (~1.34 s at 50 MHz).
- FAST_SIM, 1: when 1, the timer target is FAST_CYCLES instead of TMR_CYCLES.
- FAST_CYCLES, 32768: timer target used in simulation.
- LO_SHIFT, 2: imbalance limit while waiting; unbalanced when |diff| > sum>>LO_SHIFT (1/4 of sum).
- HI_SHIFT, 4: imbalance limit while steering; drop out when |diff| > sum-(sum>>HI_SHIFT) (15/16 of sum).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- pwr_en, in, 1: 0 forces the FSM to OFF.
- ld_vld, in, 1: 1-cycle strobe; lft_ld and rght_ld are valid in that cycle.
- lft_ld, in, LD_W: left load-cell reading, unsigned.
- rght_ld, in, LD_W: right load-cell reading, unsigned.
- en_steer, out, 1: steering enabled.
- rider_off, out, 1: no rider present.
- state, out, 2: FSM state; OFF=0, WAIT=1, STEER=2 (3 unused, decodes to OFF).
- rider_wt, out, LD_W+1: registered lft+rght from the last captured sample.

Behaviour:
- Reset: captured loads=0, rider_wt=0, timer=0, state=OFF, rider_off=1, en_steer=0.
- Capture:
  - On a clk edge with ld_vld=1, lft/rght are registered.
  - rider_wt is registered at the same edge.
  - Without ld_vld, the previous sample is held.
- Arithmetic on the captured values:
  - sum: LD_W+1 bits, no overflow.
  - diff: rght-lft, computed as LD_W+1-bit signed; |diff| is then LD_W bits, no wrap.
  - gt_min = sum > MIN_WT+WT_HYST (strict).
  - lt_min = sum < MIN_WT-WT_HYST (strict).
  - unbal_lo = |diff| > (sum>>LO_SHIFT).
  - unbal_hi = |diff| > (sum-(sum>>HI_SHIFT)).
- Timer:
  - Width is clog2 of the active target; active target T = FAST_SIM ? FAST_CYCLES : TMR_CYCLES.
  - tmr_full = (timer == T-1).
  - The timer saturates at T-1 and never wraps.
  - It is cleared on every FSM clear request.
- FSM, evaluated every cycle; priority is listed top-down:
  - pwr_en=0 -> OFF, clear timer, from any state.
  - OFF:
    - gt_min -> WAIT, clear timer.
    - else stay.
  - WAIT:
    - lt_min -> OFF.
    - else unbal_lo -> stay, clear timer.
    - else tmr_full -> STEER.
    - else timer+1.
  - STEER:
    - lt_min -> OFF.
    - else unbal_hi -> WAIT, clear timer.
    - else stay; timer holds.
- Outputs:
  - en_steer = (state==STEER) and rider_off = (state==OFF), decoded from the state flop only.
  - No combinational path from inputs to outputs.
- Latency:
  - Sample captured at edge N; state updates at edge N+1.
  - en_steer and rider_off change with state.
- Boundaries:
  - sum exactly at MIN_WT±WT_HYST: no transition.
  - Simultaneous tmr_full and unbal_lo in WAIT: unbal_lo wins, so timer clears and there is no STEER.
  - Simultaneous lt_min and unbalance: lt_min wins.
  - Reset asserted mid-operation returns everything to reset values asynchronously.
  - Illegal state code 3: next state OFF.

Test Plan:
- Reset: assert rst_n=0 mid-STEER -> rider_off=1, en_steer=0, state=0, rider_wt=0 immediately; all hold until the first ld_vld after release.
- Mount and time (FAST_SIM=1):
  - Stimulus: lft=rght=0x150 (sum 672) with ld_vld.
  - WAIT 2 edges after the strobe, rider_off=0.
  - en_steer=1 exactly 32768 cycles after entering WAIT (timer reaching 32767, then the transition edge).
- Unbalanced wait:
  - Stimulus: in WAIT, lft=0x200, rght=0x080 (|diff| 384 > 640>>2=160), re-strobed every 1000 cycles.
  - Required: timer clears each cycle, en_steer stays 0 for 100000 cycles, state=1.
- Steer dropout:
  - Stimulus: in STEER, lft=0x260, rght=0x000 (|diff| 608 > 608-38=570, sum 608 > 448).
  - Required: state->WAIT, en_steer=0, rider_off=0.
  - Then rebalancing to lft=rght=0x130 re-enables steering after 32768 cycles.
- Thresholds:
  - In OFF, sum=576 stays OFF; sum=577 -> WAIT.
  - In STEER, sum=448 stays; sum=447 -> OFF, rider_off=1.
  - Also lft=0xFFF, rght=0x000: sum 4095, |diff| 4095 computed without wrap; unbal_hi true.
- Override:
  - pwr_en=0 for 1 cycle in STEER -> state OFF next edge, timer 0.
  - After pwr_en=1 with an unchanged balanced sample -> WAIT the following edge.
